// File: rtl/conv_ctrl_pkg.sv
// conv_ctrl_pkg: shared constants and the sequencer state type for conv_ctrl.
//   DATA_BITS : signed operand width of the Conv datapath.
//   ADDR_BITS : width of feature/output addresses and of the job length.
//   RES_BITS  : full dot-product width; holds 3 * (-2^(DATA_BITS-1))^2 signed.
//   state_e   : sequencer states.
package conv_ctrl_pkg;

  localparam int DATA_BITS = 8;
  localparam int ADDR_BITS = 10;
  localparam int RES_BITS  = 2 * DATA_BITS + 2;

  // Shortest feature vector that yields at least one output.
  localparam logic [ADDR_BITS-1:0] MIN_LEN = 10'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_W_RD   = 3'd2,
    S_W_PUSH = 3'd3,
    S_F_RD   = 3'd4,
    S_F_PUSH = 3'd5,
    S_EMIT   = 3'd6,
    S_DONE   = 3'd7
  } state_e;

endpackage

// File: rtl/conv_ctrl_relu_clamp.sv
// conv_ctrl_relu_clamp: combinational ReLU, negative inputs become zero.
// Exists only when CONV_RELU_EN is defined.
//   din_i  [W-1:0] : signed value in
//   dout_o [W-1:0] : max(din_i, 0)
`ifdef CONV_RELU_EN
module conv_ctrl_relu_clamp #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] din_i,
  output logic signed [W-1:0] dout_o
);

  // Clamp on the sign bit.
  always_comb begin
    if (din_i[W-1]) begin
      dout_o = {W{1'b0}};
    end else begin
      dout_o = din_i;
    end
  end

endmodule
`endif

// File: rtl/conv_ctrl.sv
// conv_ctrl: sequencer in front of a 3-tap Conv datapath. On start it clears
// Conv, streams the three weights and N features from two read-only memories
// (1-cycle read latency) into Conv and writes each of the N-2 valid dot
// products to an output buffer over a valid/ready handshake.
// Optional feature: define CONV_RELU_EN to clamp negative results to zero.
// Ports:
//   clk, rst (async, active-low)
//   start, len            : job request, sampled in IDLE only
//   busy, done            : job status, done is a one-cycle pulse
//   w_rd_en/w_addr/w_rd_data     : weight memory port
//   if_rd_en/if_addr/if_rd_data  : feature memory port
//   conv_clear/conv_w_w/conv_if_w/conv_w_in/conv_if_in/conv_result : Conv
//   out_valid/out_ready/out_addr/out_data : result write port
// All outputs are decoded from the current state; memory data and the Conv
// result pass through combinationally in their states and are zero elsewhere.
module conv_ctrl
  import conv_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic        [ADDR_BITS-1:0] len,
  output logic                        busy,
  output logic                        done,
  output logic                        w_rd_en,
  output logic        [1:0]           w_addr,
  input  logic signed [DATA_BITS-1:0] w_rd_data,
  output logic                        if_rd_en,
  output logic        [ADDR_BITS-1:0] if_addr,
  input  logic signed [DATA_BITS-1:0] if_rd_data,
  output logic                        conv_clear,
  output logic                        conv_w_w,
  output logic                        conv_if_w,
  output logic signed [DATA_BITS-1:0] conv_w_in,
  output logic signed [DATA_BITS-1:0] conv_if_in,
  input  logic signed [RES_BITS-1:0]  conv_result,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic        [ADDR_BITS-1:0] out_addr,
  output logic signed [RES_BITS-1:0]  out_data
);

  state_e                 state_q, state_d;
  logic [1:0]             wcnt_q, wcnt_d;
  logic [ADDR_BITS-1:0]   fcnt_q, fcnt_d;
  logic [ADDR_BITS-1:0]   ocnt_q, ocnt_d;
  logic [ADDR_BITS-1:0]   len_q, len_d;
  logic signed [RES_BITS-1:0] result_s;

`ifdef CONV_RELU_EN
  conv_ctrl_relu_clamp #(.W(RES_BITS)) u_relu (
    .din_i  (conv_result),
    .dout_o (result_s)
  );
`else
  assign result_s = conv_result;
`endif

  // State and counter registers; reset aborts any job in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= 2'd0;
      fcnt_q  <= {ADDR_BITS{1'b0}};
      ocnt_q  <= {ADDR_BITS{1'b0}};
      len_q   <= {ADDR_BITS{1'b0}};
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fcnt_q  <= fcnt_d;
      ocnt_q  <= ocnt_d;
      len_q   <= len_d;
    end
  end

  // Next-state, counter updates and Moore output decode.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    fcnt_d     = fcnt_q;
    ocnt_d     = ocnt_q;
    len_d      = len_q;
    busy       = 1'b0;
    done       = 1'b0;
    w_rd_en    = 1'b0;
    w_addr     = 2'd0;
    if_rd_en   = 1'b0;
    if_addr    = {ADDR_BITS{1'b0}};
    conv_clear = 1'b0;
    conv_w_w   = 1'b0;
    conv_if_w  = 1'b0;
    conv_w_in  = {DATA_BITS{1'b0}};
    conv_if_in = {DATA_BITS{1'b0}};
    out_valid  = 1'b0;
    out_addr   = {ADDR_BITS{1'b0}};
    out_data   = {RES_BITS{1'b0}};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Short vectors produce no outputs: report done without touching memory.
          if (len >= MIN_LEN) begin
            len_d   = len;
            state_d = S_CLR;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        busy       = 1'b1;
        conv_clear = 1'b1;
        wcnt_d     = 2'd0;
        fcnt_d     = {ADDR_BITS{1'b0}};
        ocnt_d     = {ADDR_BITS{1'b0}};
        state_d    = S_W_RD;
      end
      S_W_RD: begin
        busy    = 1'b1;
        w_rd_en = 1'b1;
        w_addr  = wcnt_q;
        state_d = S_W_PUSH;
      end
      S_W_PUSH: begin
        busy      = 1'b1;
        conv_w_w  = 1'b1;
        conv_w_in = w_rd_data;
        wcnt_d    = wcnt_q + 2'd1;
        if (wcnt_q == 2'd2) begin
          state_d = S_F_RD;
        end else begin
          state_d = S_W_RD;
        end
      end
      S_F_RD: begin
        busy     = 1'b1;
        if_rd_en = 1'b1;
        if_addr  = fcnt_q;
        state_d  = S_F_PUSH;
      end
      S_F_PUSH: begin
        busy       = 1'b1;
        conv_if_w  = 1'b1;
        conv_if_in = if_rd_data;
        fcnt_d     = fcnt_q + 10'd1;
        // The first two features only prime the shift register.
        if (fcnt_q < 10'd2) begin
          state_d = S_F_RD;
        end else begin
          state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_addr  = ocnt_q;
        out_data  = result_s;
        if (out_ready) begin
          ocnt_d = ocnt_q + 10'd1;
          if (fcnt_q == len_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_F_RD;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_conv_ctrl.sv
module tb_conv_ctrl;
  import conv_ctrl_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        start = 1'b0;
  logic        [ADDR_BITS-1:0] len = 10'd0;
  logic                        busy, done;
  logic                        w_rd_en;
  logic        [1:0]           w_addr;
  logic signed [DATA_BITS-1:0] w_rd_data = 8'sd0;
  logic                        if_rd_en;
  logic        [ADDR_BITS-1:0] if_addr;
  logic signed [DATA_BITS-1:0] if_rd_data = 8'sd0;
  logic                        conv_clear, conv_w_w, conv_if_w;
  logic signed [DATA_BITS-1:0] conv_w_in, conv_if_in;
  logic signed [RES_BITS-1:0]  conv_result;
  logic                        out_valid;
  logic                        out_ready = 1'b1;
  logic        [ADDR_BITS-1:0] out_addr;
  logic signed [RES_BITS-1:0]  out_data;

  conv_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy), .done(done),
    .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
    .if_rd_en(if_rd_en), .if_addr(if_addr), .if_rd_data(if_rd_data),
    .conv_clear(conv_clear), .conv_w_w(conv_w_w), .conv_if_w(conv_if_w),
    .conv_w_in(conv_w_in), .conv_if_in(conv_if_in), .conv_result(conv_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int stall_left = 0;

  typedef struct { int addr; int data; } exp_t;
  exp_t exp_q[$];
  int   got_q[$];

  logic signed [DATA_BITS-1:0] wmem [4];
  logic signed [DATA_BITS-1:0] fmem [16];

  // Stand-in for the external Conv block: three weight taps, three feature taps.
  logic signed [DATA_BITS-1:0] wsr [3] = '{8'sd0, 8'sd0, 8'sd0};
  logic signed [DATA_BITS-1:0] fsr [3] = '{8'sd0, 8'sd0, 8'sd0};

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  function automatic logic any_out();
    return |{busy, done, w_rd_en, w_addr, if_rd_en, if_addr, conv_clear, conv_w_w,
             conv_if_w, conv_w_in, conv_if_in, out_valid, out_addr, out_data};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memories with one cycle of read latency.
  always @(posedge clk) begin
    if (w_rd_en) w_rd_data <= wmem[w_addr];
    if (if_rd_en) if_rd_data <= fmem[if_addr[3:0]];
  end

  always @(posedge clk) begin
    if (conv_clear) begin
      for (int i = 0; i < 3; i++) begin
        wsr[i] <= 8'sd0;
        fsr[i] <= 8'sd0;
      end
    end else begin
      if (conv_w_w) begin
        wsr[0] <= wsr[1]; wsr[1] <= wsr[2]; wsr[2] <= conv_w_in;
      end
      if (conv_if_w) begin
        fsr[0] <= fsr[1]; fsr[1] <= fsr[2]; fsr[2] <= conv_if_in;
      end
    end
  end

  assign conv_result = 18'(int'(fsr[0]) * int'(wsr[0]) + int'(fsr[1]) * int'(wsr[1])
                           + int'(fsr[2]) * int'(wsr[2]));

  // Drive out_ready stalls, then check the output port against the model queue.
  always @(negedge clk) begin
    if (stall_left > 0 && out_valid) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = 1'b1;
    end
    if (rst) begin
      chk("done_with_valid", done && out_valid, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          chk("out_addr", out_addr, exp_q[0].addr);
          chk("out_data", out_data, exp_q[0].data);
          chk("read_in_emit", w_rd_en || if_rd_en, 0);
          if (out_ready) begin
            got_q.push_back(int'(out_data));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic load_case1();
    wmem[0] = 8'sd1; wmem[1] = 8'sd2; wmem[2] = 8'sd3;
    for (int i = 0; i < 5; i++) fmem[i] = 8'(i + 1);
  endtask

  // Expected outputs straight from y[j] = x[j]W0 + x[j+1]W1 + x[j+2]W2.
  task automatic build_expect(input int n);
    exp_t e;
    exp_q.delete();
    got_q.delete();
    for (int j = 0; j <= n - 3; j++) begin
      e.addr = j;
      e.data = int'(fmem[j]) * int'(wmem[0]) + int'(fmem[j+1]) * int'(wmem[1])
             + int'(fmem[j+2]) * int'(wmem[2]);
`ifdef CONV_RELU_EN
      if (e.data < 0) e.data = 0;
`endif
      exp_q.push_back(e);
    end
  endtask

  task automatic run_job(input int n, input int stall, input bit poke);
    int s, got, exp_done;
    build_expect(n);
    stall_left = stall;
    exp_done = (n < 3) ? 1 : 3 * n + 6 + stall;
    @(posedge clk); #1;
    start = 1'b1; len = 10'(n); s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    got = -1;
    for (int k = 0; k < 400 && got < 0; k++) begin
      @(negedge clk);
      if (poke && (cyc - s) == 5) begin
        start = 1'b1; len = 10'd3;
      end else begin
        start = 1'b0; len = 10'(n);
      end
      chk("busy_in_job", busy, 1);
      if (n < 3) chk("no_read_short", w_rd_en || if_rd_en || out_valid, 0);
      if (done) got = cyc - s;
    end
    start = 1'b0;
    if (got < 0) chk("done_timeout", 0, 1);
    chk("done_cycle", got, exp_done);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("done_pulse", done, 0);
    chk("all_emitted", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bit hit;
    #1;
    chk("reset_outputs", any_out(), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outputs", any_out(), 0);

    // Basic job.
    load_case1();
    run_job(5, 0, 0);
    chk("n_out_case1", got_q.size(), 3);
    chk("y0_case1", got_q[0], 14);
    chk("y1_case1", got_q[1], 20);
    chk("y2_case1", got_q[2], 26);

    // Negative result, with and without the clamp.
    wmem[0] = -8'sd1; wmem[1] = 8'sd0; wmem[2] = 8'sd0;
    fmem[0] = 8'sd5; fmem[1] = 8'sd1; fmem[2] = 8'sd1;
    run_job(3, 0, 0);
`ifdef CONV_RELU_EN
    chk("y_neg_relu", got_q[0], 0);
`else
    chk("y_neg_raw", got_q[0], -5);
`endif

    // Back-pressure in the first EMIT.
    load_case1();
    run_job(5, 4, 0);
    chk("y0_stall", got_q[0], 14);
    chk("y2_stall", got_q[2], 26);

    // Too short: immediate done, nothing else.
    run_job(2, 0, 0);
    chk("n_out_short", got_q.size(), 0);

    // Most negative operands everywhere.
    for (int i = 0; i < 3; i++) begin
      wmem[i] = -8'sd128;
      fmem[i] = -8'sd128;
    end
    run_job(3, 0, 0);
    chk("y_extreme", got_q[0], 49152);

    // Reset during the second F_PUSH, then a clean rerun with a stray start.
    load_case1();
    exp_q.delete();
    @(posedge clk); #1;
    start = 1'b1; len = 10'd5; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if ((cyc - s) == 11) hit = 1'b1;
    end
    chk("reached_fpush2", hit, 1);
    chk("fpush2_state", conv_if_w, 1);
    #1 rst = 1'b0;
    #1 chk("abort_outputs", any_out(), 0);
    @(negedge clk);
    chk("abort_hold", any_out(), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("after_abort_idle", busy, 0);
    run_job(5, 0, 1);
    chk("n_out_rerun", got_q.size(), 3);
    chk("y0_rerun", got_q[0], 14);
    chk("y1_rerun", got_q[1], 20);
    chk("y2_rerun", got_q[2], 26);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_ctrl.md
# conv_ctrl

Sequencer that sits directly upstream of the 3-tap `Conv` datapath: on `start` it clears `Conv`, streams three weights and an N-element feature vector from two read-only memories into `Conv`'s shift registers, and writes each valid dot product to an output buffer through a valid/ready handshake. It produces the N−2 outputs of a 1-D valid-mode convolution, y[j] = x[j]·W0 + x[j+1]·W1 + x[j+2]·W2, where Wk is the word at weight address k.

## Interface
- `DATA_BITS`, from `define.vh` (8): signed operand width, identical to `Conv`.
- `ADDR_BITS`, 10: width of feature/output addresses and `len`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a job; sampled only in IDLE.
- `len` in ADDR_BITS: feature count N (unsigned), sampled with `start`.
- `busy` out 1: high from the cycle after `start` accept through the DONE state.
- `done` out 1: one-cycle pulse at job end.
- `w_rd_en` out 1 / `w_addr` out 2 / `w_rd_data` in DATA_BITS: weight memory, 1-cycle read latency.
- `if_rd_en` out 1 / `if_addr` out ADDR_BITS / `if_rd_data` in DATA_BITS: feature memory, 1-cycle read latency.
- `conv_clear`, `conv_w_w`, `conv_if_w` out 1; `conv_w_in`, `conv_if_in` out DATA_BITS: drive `Conv`.
- `conv_result` in 2·DATA_BITS+2: `Conv` result, combinational.
- `out_valid` out 1 / `out_ready` in 1 / `out_addr` out ADDR_BITS / `out_data` out 2·DATA_BITS+2: result write port.

## Operation
- States: IDLE, CLR, W_RD, W_PUSH, F_RD, F_PUSH, EMIT, DONE. Counters: `wcnt` (0..2), `fcnt` (next feature address), `ocnt` (next output address).
- IDLE: `start`=1 with `len`≥3 → CLR and latch `len`. `start`=1 with `len`<3 → DONE; no reads, no outputs. `start` outside IDLE is ignored.
- CLR: `conv_clear`=1; clear all counters → W_RD.
- W_RD: `w_rd_en`=1, `w_addr`=`wcnt` → W_PUSH.
- W_PUSH: `conv_w_w`=1, `conv_w_in`=`w_rd_data`; `wcnt`++; if `wcnt`==2, go to F_RD, else W_RD.
- F_RD: `if_rd_en`=1, `if_addr`=`fcnt` → F_PUSH.
- F_PUSH: `conv_if_w`=1, `conv_if_in`=`if_rd_data`; `fcnt`++; if `fcnt` (before increment) <2, go to F_RD, else EMIT.
- EMIT: `out_valid`=1, `out_addr`=`ocnt`, `out_data`=`conv_result` (see Configuration). Stay in EMIT while `out_ready`=0; `out_data` and `out_addr` stay stable. On `out_ready`=1, `ocnt`++; if `fcnt`==`len`, go to DONE, else F_RD.
- DONE: `done`=1 → IDLE.
- Outputs are Moore-decoded from the state. Memory data passes combinationally to `conv_*_in`.
- `out_data` has the full width, with no truncation. Worst case 3·(−2^(DATA_BITS−1))² fits in 2·DATA_BITS+2 bits signed.

## Timing
- Reset values: every output 0, state IDLE, counters 0. Reset mid-job aborts immediately. Any partial `Conv` contents are flushed by CLR on the next job.
- With `start` in cycle 0 and `out_ready` held high:
  - CLR in cycle 1.
  - Weights in cycles 2–7.
  - Feature prime in cycles 8–11.
  - 3 cycles per output after that.
  - `done` in cycle 3N+6.
- Each cycle `out_ready` is low in EMIT adds one cycle. `done` is never asserted in the same cycle as `out_valid`.
- `len`<3: `done` in cycle 1, `busy` high only in cycle 1.

## Configuration
- `CONV_RELU_EN` defined: `out_data` = 0 when `conv_result` is negative, else `conv_result`.
- `CONV_RELU_EN` undefined: `out_data` = `conv_result` unmodified, signed.

## Structure
- Shared header `define.vh` holds `DATA_BITS`, the result width constant (2·DATA_BITS+2), and the state encodings.
- One sub-module, `relu_clamp`: combinational, parameterised by width, instantiated only under `CONV_RELU_EN`.
- The `Conv` instance sits outside this block, in the parent.

## Test plan
- Weights [1,2,3], features [1,2,3,4,5], `len`=5, `out_ready`=1 → `out_data` 14, 20, 26 at `out_addr` 0, 1, 2; `done` in cycle 21.
- Weights [−1,0,0], features [5,1,1], `len`=3:
  - With `CONV_RELU_EN`: `out_data`=0.
  - Without it: `out_data`=−5 (0x3FFFB).
- Same as the first case, but `out_ready` low for 4 cycles in the first EMIT → `out_valid`, `out_data`=14 and `out_addr`=0 held stable; no reads during the stall; `done` in cycle 25.
- `len`=2 → `done` in cycle 1; no `w_rd_en`, `if_rd_en` or `out_valid` at any point.
- Weights all −128, features all −128, `len`=3 → `out_data`=49152, with no overflow.
- Assert `rst` low during the second F_PUSH → all outputs 0 at once. A second `start` raised while `busy` is ignored. A new job with the first case's data then reproduces 14, 20, 26.
